paper_float_dot_seq: RTL and testbench
======================================

PAPER_FLOAT_DOT_SEQ -- requirements
Module: paper_float_dot_seq

Interface
REQ-001 SHALL have parameter EXP, default 5, exponent width.
REQ-002 SHALL have parameter FRAC, default 10, fraction width; word WIDTH = 1+EXP+FRAC.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port inA, input, WIDTH, multiplicand element.
REQ-006 SHALL have port inB, input, WIDTH, multiplier element.
REQ-007 SHALL have port inLast, input, 1, marks the final element of a vector.
REQ-008 SHALL have port inValid, input, 1, element pair valid.
REQ-009 SHALL have port inReady, output, 1, sequencer accepts element.
REQ-010 SHALL have port outData, output, WIDTH, completed dot product.
REQ-011 SHALL have port outValid, output, 1, outData valid.
REQ-012 SHALL have port outReady, input, 1, consumer accepts result.
REQ-013 SHALL have port outCount, output, 16, number of elements accumulated into outData.

Function
REQ-014 SHALL instantiate one float fused multiply-add (a*b+c, same EXP/FRAC, round-to-nearest-even, non-IEEE-compliant mode) with a=inA, b=inB, c=accumulator register.
REQ-015 SHALL implement states IDLE (no element accepted this vector), ACCUM (at least one element accepted), HOLD (result pending).
REQ-016 SHALL drive inReady=1 in IDLE and ACCUM, 0 in HOLD.
REQ-017 SHALL treat an input transfer as inValid && inReady; on transfer, accumulator <= MAC result and count <= count+1.
REQ-018 On transfer with inLast=0 SHALL go to ACCUM; with inLast=1 SHALL go to HOLD, load outData with the MAC result and outCount with count+1, and assert outValid next cycle.
REQ-019 Latency SHALL be one cycle from last-element transfer to outValid=1.
REQ-020 In HOLD SHALL keep outData, outCount, outValid stable until outValid && outReady.
REQ-021 On output transfer SHALL go to IDLE, clear outValid, reload accumulator with the start value, clear count; inReady rises the following cycle (no same-cycle in/out overlap).
REQ-022 Without inValid SHALL hold state and accumulator (bubbles allowed mid-vector).
REQ-023 Count SHALL saturate at 16'hFFFF; accumulation continues while saturated.
REQ-024 Start value SHALL be +0 (all-zero word) unless REQ-029 applies.
REQ-025 NaN/Inf SHALL propagate purely per MAC result; sequencer has no special handling.

Reset
REQ-026 On reset SHALL enter IDLE, accumulator = start value, count = 0, outValid = 0, outData = 0, outCount = 0.
REQ-027 Reset mid-vector or in HOLD SHALL discard partial sum/pending result with no output transfer; reset dominates simultaneous in/out transfers.
REQ-028 inReady SHALL be 1 the first cycle after reset deasserts.

Configuration
REQ-029 With macro PAPER_FLOAT_DOT_INIT_EN defined SHALL add input port cInit (WIDTH), sampled as start value at reset and on each output transfer (REQ-021); bias added once per vector.
REQ-030 Without PAPER_FLOAT_DOT_INIT_EN SHALL omit cInit and use +0 start value.

Verification (EXP=5, FRAC=10)
REQ-031 Vector (0x3C00,0x4000),(0x4000,0x4200,last), outReady=1 -> outData=0x4800 (8.0), outCount=2, outValid one cycle after last transfer.
REQ-032 Single element (0x4200,0x3800,last) -> outData=0x3E00 (1.5), outCount=1.
REQ-033 Result pending with outReady=0 for 5 cycles -> outValid/outData held, inReady=0 throughout; outReady=1 -> IDLE, inReady=1 next cycle.
REQ-034 One element (0x4000,0x4000) accepted, reset pulsed, then (0x3C00,0x3C00,last) -> outData=0x3C00, outCount=1, no output for the discarded vector.
REQ-035 inValid gaps of 3 cycles between elements of REQ-031 vector -> identical result 0x4800, outCount=2.
REQ-036 PAPER_FLOAT_DOT_INIT_EN defined, cInit=0x3C00, (0x4000,0x4000,last) -> outData=0x4500 (5.0); second vector (0x3C00,0x3C00,last) -> 0x4000 (bias applied again).

Source files
------------

// File: rtl/paper_float_dot_seq.sv
// Sequential floating-point dot product: one fused multiply-add per accepted element pair.
// Optional macro PAPER_FLOAT_DOT_INIT_EN adds a cInit port that biases every vector.
module paper_float_dot_seq #(
  parameter int EXP = 5,
  parameter int FRAC = 10,
  localparam int WIDTH = 1 + EXP + FRAC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inLast,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic [15:0]      outCount,
`ifdef PAPER_FLOAT_DOT_INIT_EN
  input  logic [WIDTH-1:0] cInit,
`endif
  output logic [1:0]       fsm_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holds its payload stable while valid is high and ready is low.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int WP = 2 * (FRAC + 1);
  localparam int SH = 2 * FRAC + 6;
  localparam int WS = WP + SH + 1;
  localparam logic signed [15:0] BIAS = 16'((1 << (EXP - 1)) - 1);
  localparam logic signed [15:0] EMAX = 16'((1 << EXP) - 1);
  localparam logic signed [15:0] SH_S = 16'(SH);
  localparam logic signed [15:0] TWOF = 16'(2 * FRAC);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc, mac, start_val;
  logic [15:0]      count, cnt_next;

`ifdef PAPER_FLOAT_DOT_INIT_EN
  assign start_val = cInit;
`else
  assign start_val = '0;
`endif

  // ---------------- fused multiply-add: mac = inA * inB + acc ----------------
  logic sa, sb, sc, sp, rs;
  logic [EXP-1:0]  ea, eb, ec;
  logic [FRAC-1:0] fa, fb, fc, frac_n;
  logic za, zb, zc, a_inf, b_inf, c_inf, any_nan, p_inf;
  logic [FRAC:0] ma, mb, mc, mant_r;
  logic [WP-1:0] mp, mc_al;
  logic signed [15:0] ep, ec_s, diff, emin, er;
  logic [15:0] sh, lead;
  logic [WS-1:0] lp, lc, sum, norm;
  logic guard, sticky, rnd;

  assign {sa, ea, fa} = inA;
  assign {sb, eb, fb} = inB;
  assign {sc, ec, fc} = acc;

  always_comb begin
    // Subnormal inputs flush to zero; all-ones exponent is Inf/NaN.
    za = (ea == '0);
    zb = (eb == '0);
    zc = (ec == '0);
    a_inf = (ea == '1) && (fa == '0);
    b_inf = (eb == '1) && (fb == '0);
    c_inf = (ec == '1) && (fc == '0);
    sp = sa ^ sb;
    p_inf = a_inf | b_inf;
    any_nan = ((ea == '1) && (fa != '0)) || ((eb == '1) && (fb != '0)) ||
              ((ec == '1) && (fc != '0)) || (a_inf && zb) || (b_inf && za) ||
              (p_inf && c_inf && (sp != sc));
    ma = za ? '0 : {1'b1, fa};
    mb = zb ? '0 : {1'b1, fb};
    mc = zc ? '0 : {1'b1, fc};
    mp = WP'(ma) * WP'(mb);
    mc_al = WP'({mc, {FRAC{1'b0}}});
    ep = 16'(ea) + 16'(eb) - BIAS;
    ec_s = 16'(ec);
    diff = ep - ec_s;
    // Shift the larger-exponent operand left so the sum stays exact; clamping
    // the shift keeps the far-smaller operand below the rounding position.
    if (diff > 0) begin
      sh = (diff > SH_S) ? SH_S : diff;
      lp = WS'(mp) << sh;
      lc = WS'(mc_al);
      emin = ep - sh;
    end else begin
      sh = (-diff > SH_S) ? SH_S : -diff;
      lp = WS'(mp);
      lc = WS'(mc_al) << sh;
      emin = ec_s - sh;
    end
    if (sp == sc) begin
      sum = lp + lc;
      rs = sp;
    end else if (lp >= lc) begin
      sum = lp - lc;
      rs = sp;
    end else begin
      sum = lc - lp;
      rs = sc;
    end
    lead = '0;
    for (int i = 0; i < WS; i++) begin
      if (sum[i]) lead = 16'(i);
    end
    norm = sum << (16'(WS - 1) - lead);
    frac_n = norm[WS-2 -: FRAC];
    guard = norm[WS-2-FRAC];
    sticky = |norm[WS-3-FRAC:0];
    rnd = guard & (sticky | frac_n[0]);
    mant_r = {1'b0, frac_n} + {{FRAC{1'b0}}, rnd};
    er = lead + emin - TWOF + 16'(mant_r[FRAC]);
    if (any_nan)
      mac = {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};
    else if (p_inf)
      mac = {sp, {EXP{1'b1}}, {FRAC{1'b0}}};
    else if (c_inf)
      mac = {sc, {EXP{1'b1}}, {FRAC{1'b0}}};
    else if (!norm[WS-1])
      mac = {sp & sc, {(EXP+FRAC){1'b0}}};
    else if (er >= EMAX)
      mac = {rs, {EXP{1'b1}}, {FRAC{1'b0}}};
    else if (er <= 16'sd0)
      mac = {rs, {(EXP+FRAC){1'b0}}};
    else
      mac = {rs, er[EXP-1:0], mant_r[FRAC-1:0]};
  end

  // ---------------- sequencer ----------------
  assign inReady = (state != HOLD);
  assign fsm_state = state;
  assign cnt_next = (count == 16'hFFFF) ? count : count + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc <= start_val;
      count <= '0;
      outValid <= 1'b0;
      outData <= '0;
      outCount <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (inValid) begin
            acc <= mac;
            count <= cnt_next;
            if (inLast) begin
              state <= HOLD;
              outData <= mac;
              outCount <= cnt_next;
              outValid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (outReady) begin
            state <= IDLE;
            outValid <= 1'b0;
            acc <= start_val;
            count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_paper_float_dot_seq.sv
// Scoreboard bench for paper_float_dot_seq: driver pushes hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_paper_float_dot_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] inA, inB;
  logic        inLast, inValid, inReady;
  logic [15:0] outData;
  logic        outValid, outReady;
  logic [15:0] outCount;
  logic [1:0]  fsm_state;
`ifdef PAPER_FLOAT_DOT_INIT_EN
  logic [15:0] cInit = 16'h3C00;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  paper_float_dot_seq #(.EXP(5), .FRAC(10)) dut (
    .clock(clock), .reset(reset), .inA(inA), .inB(inB), .inLast(inLast),
    .inValid(inValid), .inReady(inReady), .outData(outData), .outValid(outValid),
    .outReady(outReady), .outCount(outCount),
`ifdef PAPER_FLOAT_DOT_INIT_EN
    .cInit(cInit),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [31:0] e;
    if (!reset && outValid && outReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got data %h count %0d, expected none", outData, outCount);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(outData), 32'(e[15:0]));
        check("out_count", 32'(outCount), 32'(e[31:16]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    inValid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int k;
    inA = a;
    inB = b;
    inLast = last;
    inValid = 1'b1;
    k = 0;
    while (!inReady && k < 50) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (k == 50) check("in_ready_timeout", 32'(inReady), 32'd1);
    @(posedge clock);
    #1;
    inValid = 1'b0;
    if (last) check("latency_out_valid", 32'(outValid), 32'd1);
  endtask

  task automatic expect_result(input logic [15:0] cnt, input logic [15:0] data);
    exp_q.push_back({cnt, data});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    reset = 1'b1;
    inA = '0;
    inB = '0;
    inLast = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 32'(outValid), 32'd0);
    check("rst_out_data", 32'(outData), 32'd0);
    check("rst_out_count", 32'(outCount), 32'd0);
    check("rst_in_ready", 32'(inReady), 32'd1);
    check("rst_state", 32'(fsm_state), 32'd0);

`ifdef PAPER_FLOAT_DOT_INIT_EN
    // bias 1.0 added once per vector: 2*2+1 = 5, then 1*1+1 = 2
    expect_result(16'd1, 16'h4500);
    send(16'h4000, 16'h4000, 1'b1);
    expect_result(16'd1, 16'h4000);
    send(16'h3C00, 16'h3C00, 1'b1);
    idle(3);
`else
    // 1*2 + 2*3 = 8
    expect_result(16'd2, 16'h4800);
    send(16'h3C00, 16'h4000, 1'b0);
    send(16'h4000, 16'h4200, 1'b1);
    idle(2);

    // single element 3*0.5 = 1.5
    expect_result(16'd1, 16'h3E00);
    send(16'h4200, 16'h3800, 1'b1);
    idle(2);

    // result held under back-pressure: 4*4 = 16
    outReady = 1'b0;
    expect_result(16'd1, 16'h4C00);
    send(16'h4400, 16'h4400, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(outValid), 32'd1);
      check("hold_out_data", 32'(outData), 32'h4C00);
      check("hold_in_ready", 32'(inReady), 32'd0);
      @(posedge clock);
      #1;
    end
    outReady = 1'b1;
    @(posedge clock);
    #1;
    check("release_out_valid", 32'(outValid), 32'd0);
    check("release_in_ready", 32'(inReady), 32'd1);

    // partial vector discarded by reset
    send(16'h4000, 16'h4000, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_state", 32'(fsm_state), 32'd0);
    check("midrst_out_valid", 32'(outValid), 32'd0);
    expect_result(16'd1, 16'h3C00);
    send(16'h3C00, 16'h3C00, 1'b1);
    idle(2);

    // bubbles between elements do not disturb the sum
    expect_result(16'd2, 16'h4800);
    send(16'h3C00, 16'h4000, 1'b0);
    idle(3);
    send(16'h4000, 16'h4200, 1'b1);
    idle(2);

    // 6 + (-2*2) = 2
    expect_result(16'd2, 16'h4000);
    send(16'h4200, 16'h4000, 1'b0);
    send(16'hC000, 16'h4000, 1'b1);
    idle(2);

    // exact cancellation gives +0
    expect_result(16'd2, 16'h0000);
    send(16'h3C00, 16'h3C00, 1'b0);
    send(16'hBC00, 16'h3C00, 1'b1);
    idle(2);

    // 1 + 2^-11 is a tie, rounds to even (1.0)
    expect_result(16'd2, 16'h3C00);
    send(16'h3C00, 16'h3C00, 1'b0);
    send(16'h3C00, 16'h1000, 1'b1);
    idle(2);

    // 1 + 1.5 ulp is a tie, rounds to even (1 + 2 ulp)
    expect_result(16'd2, 16'h3C02);
    send(16'h3C00, 16'h3C00, 1'b0);
    send(16'h3C00, 16'h1600, 1'b1);
    idle(2);

    // count saturates at 0xFFFF while accumulation continues
    expect_result(16'hFFFF, 16'h3C00);
    for (int i = 0; i < 65540; i++) send(16'h0000, 16'h3C00, 1'b0);
    send(16'h3C00, 16'h3C00, 1'b1);
    idle(3);
`endif

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
